// File: rtl/decode_pkg.sv
// Shared constants for the instruction decode stage: opcode values,
// instruction field positions and the immediate-extension modes.
package decode_pkg;

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;

    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SA_LSB     = 6;
    localparam int FUNCT_LSB  = 0;
    localparam int FIELD6_W   = 6;
    localparam int IMM_W      = 16;
    localparam int INDEX_W    = 26;

    typedef enum logic [1:0] {SIGN, ZERO, UPPER} ext_mode_e;

    function automatic ext_mode_e ext_mode(input logic [FIELD6_W-1:0] opcode);
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: return ZERO;
            OP_LUI:                   return UPPER;
            default:                  return SIGN;
        endcase
    endfunction

endpackage

// File: rtl/decode_pipe_stage_if.sv
// Upstream, downstream, hazard and writeback signals of the decode stage.
interface decode_pipe_stage_if #(
    parameter int NB_DATA     = 32,
    parameter int NB_REGISTER = 5
);
    logic                   i_valid;
    logic                   o_ready;
    logic [NB_DATA-1:0]     i_instruction;
    logic [NB_DATA-1:0]     i_pc_next;
    logic                   i_ready;
    logic                   i_flush;
    logic                   i_ex_mem_read;
    logic [NB_REGISTER-1:0] i_ex_rt;
    logic                   i_wb_enable;
    logic [NB_REGISTER-1:0] i_wb_sel;
    logic [NB_DATA-1:0]     i_wb_data;
    logic                   o_valid;
    logic [5:0]             o_opcode;
    logic [5:0]             o_funct;
    logic [NB_REGISTER-1:0] o_rs;
    logic [NB_REGISTER-1:0] o_rt;
    logic [NB_REGISTER-1:0] o_rd;
    logic [NB_REGISTER-1:0] o_sa;
    logic [NB_DATA-1:0]     o_data_rs;
    logic [NB_DATA-1:0]     o_data_rt;
    logic [NB_DATA-1:0]     o_extended;
    logic [25:0]            o_instruction_index;
    logic [NB_DATA-1:0]     o_pc_next;
    logic                   o_hazard_stall;

    modport master (
        output i_valid, i_instruction, i_pc_next, i_ready, i_flush,
               i_ex_mem_read, i_ex_rt, i_wb_enable, i_wb_sel, i_wb_data,
        input  o_ready, o_valid, o_opcode, o_funct, o_rs, o_rt, o_rd, o_sa,
               o_data_rs, o_data_rt, o_extended, o_instruction_index,
               o_pc_next, o_hazard_stall
    );

    modport slave (
        input  i_valid, i_instruction, i_pc_next, i_ready, i_flush,
               i_ex_mem_read, i_ex_rt, i_wb_enable, i_wb_sel, i_wb_data,
        output o_ready, o_valid, o_opcode, o_funct, o_rs, o_rt, o_rd, o_sa,
               o_data_rs, o_data_rt, o_extended, o_instruction_index,
               o_pc_next, o_hazard_stall
    );
endinterface

// File: rtl/decode_pipe_stage_register_file_bypass.sv
// Two-read, one-write register file; a write in the same cycle is forwarded
// to the read ports so a decode capturing that register sees the new value.
module register_file_bypass #(
    parameter int NB_DATA            = 32,
    parameter int NB_REGISTER        = 5,
    parameter int N_REGS             = 2**NB_REGISTER,
    parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_wb_enable,
    input  logic [NB_REGISTER-1:0] i_wb_sel,
    input  logic [NB_DATA-1:0]     i_wb_data,
    input  logic [NB_REGISTER-1:0] i_rs,
    input  logic [NB_REGISTER-1:0] i_rt,
    output logic [NB_DATA-1:0]     o_data_rs,
    output logic [NB_DATA-1:0]     o_data_rt
);
    logic [NB_DATA-1:0] regs [N_REGS];
    logic               wr_en;

    assign wr_en = i_wb_enable && ((i_wb_sel != '0) || !ZERO_REG_HARDWIRED);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[i_wb_sel] <= i_wb_data;
        end
    end

    // Hardwired zero wins over the bypass path.
    function automatic logic [NB_DATA-1:0] read_port(input logic [NB_REGISTER-1:0] sel);
        if (ZERO_REG_HARDWIRED && (sel == '0)) return '0;
        if (wr_en && (i_wb_sel == sel))        return i_wb_data;
        return regs[sel];
    endfunction

    assign o_data_rs = read_port(i_rs);
    assign o_data_rt = read_port(i_rt);
endmodule

// File: rtl/decode_pipe_stage.sv
// Instruction decode pipeline stage: field split, immediate extension,
// register read with writeback bypass and load-use bubble insertion.
module decode_pipe_stage
    import decode_pkg::*;
#(
    parameter int NB_DATA            = 32,
    parameter int NB_REGISTER        = 5,
    parameter int N_REGS             = 2**NB_REGISTER,
    parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    decode_pipe_stage_if.slave bus
);
    logic [NB_DATA-1:0]      instr_p0;
    logic [FIELD6_W-1:0]     opcode_p0;
    logic [NB_REGISTER-1:0]  rs_p0, rt_p0;
    logic [NB_DATA-1:0]      data_rs_p0, data_rt_p0;
    logic                    hazard_p0, slot_free_p0, ready_p0, accept_p0;

    logic                    vld_p1, stall_p1;
    logic [FIELD6_W-1:0]     opcode_p1, funct_p1;
    logic [NB_REGISTER-1:0]  rs_p1, rt_p1, rd_p1, sa_p1;
    logic [NB_DATA-1:0]      data_rs_p1, data_rt_p1, extended_p1, pc_next_p1;
    logic [INDEX_W-1:0]      index_p1;

    function automatic logic [NB_DATA-1:0] extend_imm(input logic [IMM_W-1:0] imm,
                                                      input ext_mode_e      mode);
        logic signed [IMM_W-1:0] simm;
        simm = imm;
        case (mode)
            ZERO:    return NB_DATA'(imm);
            UPPER:   return NB_DATA'({imm, 16'b0});
            default: return NB_DATA'(simm);
        endcase
    endfunction

    assign instr_p0  = bus.i_instruction;
    assign opcode_p0 = instr_p0[OPCODE_LSB +: FIELD6_W];
    assign rs_p0     = instr_p0[RS_LSB +: NB_REGISTER];
    assign rt_p0     = instr_p0[RT_LSB +: NB_REGISTER];

    assign hazard_p0    = bus.i_valid && bus.i_ex_mem_read && (bus.i_ex_rt != '0) &&
                          ((bus.i_ex_rt == rs_p0) || (bus.i_ex_rt == rt_p0));
    assign slot_free_p0 = !vld_p1 || bus.i_ready;
    assign ready_p0     = slot_free_p0 && !hazard_p0 && !bus.i_flush;
    assign accept_p0    = bus.i_valid && ready_p0;

    register_file_bypass #(
        .NB_DATA            (NB_DATA),
        .NB_REGISTER        (NB_REGISTER),
        .N_REGS             (N_REGS),
        .ZERO_REG_HARDWIRED (ZERO_REG_HARDWIRED)
    ) u_regfile (
        .i_clock     (i_clock),
        .i_reset_n   (i_reset_n),
        .i_wb_enable (bus.i_wb_enable),
        .i_wb_sel    (bus.i_wb_sel),
        .i_wb_data   (bus.i_wb_data),
        .i_rs        (rs_p0),
        .i_rt        (rt_p0),
        .o_data_rs   (data_rs_p0),
        .o_data_rt   (data_rt_p0)
    );

    // p0 -> p1: flush beats hazard beats accept; a stalled output slot holds everything.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vld_p1      <= 1'b0;
            stall_p1    <= 1'b0;
            opcode_p1   <= '0;
            funct_p1    <= '0;
            rs_p1       <= '0;
            rt_p1       <= '0;
            rd_p1       <= '0;
            sa_p1       <= '0;
            data_rs_p1  <= '0;
            data_rt_p1  <= '0;
            extended_p1 <= '0;
            pc_next_p1  <= '0;
            index_p1    <= '0;
        end else if (bus.i_flush) begin
            vld_p1   <= 1'b0;
            stall_p1 <= 1'b0;
        end else if (slot_free_p0) begin
            vld_p1   <= accept_p0;
            stall_p1 <= hazard_p0;
            if (accept_p0) begin
                opcode_p1   <= opcode_p0;
                funct_p1    <= instr_p0[FUNCT_LSB +: FIELD6_W];
                rs_p1       <= rs_p0;
                rt_p1       <= rt_p0;
                rd_p1       <= instr_p0[RD_LSB +: NB_REGISTER];
                sa_p1       <= instr_p0[SA_LSB +: NB_REGISTER];
                data_rs_p1  <= data_rs_p0;
                data_rt_p1  <= data_rt_p0;
                extended_p1 <= extend_imm(instr_p0[IMM_W-1:0], ext_mode(opcode_p0));
                pc_next_p1  <= bus.i_pc_next;
                index_p1    <= instr_p0[INDEX_W-1:0];
            end
        end
    end

    assign bus.o_ready             = ready_p0;
    assign bus.o_valid             = vld_p1;
    assign bus.o_hazard_stall      = stall_p1;
    assign bus.o_opcode            = opcode_p1;
    assign bus.o_funct             = funct_p1;
    assign bus.o_rs                = rs_p1;
    assign bus.o_rt                = rt_p1;
    assign bus.o_rd                = rd_p1;
    assign bus.o_sa                = sa_p1;
    assign bus.o_data_rs           = data_rs_p1;
    assign bus.o_data_rt           = data_rt_p1;
    assign bus.o_extended          = extended_p1;
    assign bus.o_instruction_index = index_p1;
    assign bus.o_pc_next           = pc_next_p1;
endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed bench for decode_pipe_stage: decode vector table plus hazard,
// bypass, backpressure/flush and asynchronous reset sequences.
module tb_decode_pipe_stage;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    decode_pipe_stage_if #(.NB_DATA(32), .NB_REGISTER(5)) bus ();

    decode_pipe_stage #(
        .NB_DATA(32), .NB_REGISTER(5), .N_REGS(32), .ZERO_REG_HARDWIRED(1'b1)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [31:0] ext;
        logic [25:0] index;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_valid       = 1'b0;
        bus.i_instruction = '0;
        bus.i_pc_next     = '0;
        bus.i_ready       = 1'b1;
        bus.i_flush       = 1'b0;
        bus.i_ex_mem_read = 1'b0;
        bus.i_ex_rt       = '0;
        bus.i_wb_enable   = 1'b0;
        bus.i_wb_sel      = '0;
        bus.i_wb_data     = '0;
    endtask

    initial begin
        //            instr         pc          op     rs  rt  rd  funct  ext           index
        vecs[0] = '{32'h2008FFFF, 32'h00001004, 6'h08, 0,  8,  31, 6'h3F, 32'hFFFFFFFF, 26'h008FFFF};
        vecs[1] = '{32'h3508FFFF, 32'h00001008, 6'h0D, 8,  8,  31, 6'h3F, 32'h0000FFFF, 26'h108FFFF};
        vecs[2] = '{32'h3C081234, 32'h0000100C, 6'h0F, 0,  8,  2,  6'h34, 32'h12340000, 26'h0081234};
        vecs[3] = '{32'h31088000, 32'h00001010, 6'h0C, 8,  8,  16, 6'h00, 32'h00008000, 26'h1088000};
        vecs[4] = '{32'h38008001, 32'h00001014, 6'h0E, 0,  0,  16, 6'h01, 32'h00008001, 26'h0008001};
        vecs[5] = '{32'h012A4020, 32'h00001018, 6'h00, 9,  10, 8,  6'h20, 32'h00004020, 26'h12A4020};
        vecs[6] = '{32'h8D2CFFF0, 32'h0000101C, 6'h23, 9,  12, 31, 6'h30, 32'hFFFFFFF0, 26'h12CFFF0};

        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("reset_o_valid", 32'(bus.o_valid), 32'd0);
        chk("reset_hazard_stall", 32'(bus.o_hazard_stall), 32'd0);
        chk("reset_extended", bus.o_extended, 32'd0);
        chk("reset_pc_next", bus.o_pc_next, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", 32'(bus.o_ready), 32'd1);

        // Decode table: each vector accepted with i_ready=1, checked one cycle later.
        for (int i = 0; i < 7; i++) begin
            bus.i_valid       = 1'b1;
            bus.i_instruction = vecs[i].instr;
            bus.i_pc_next     = vecs[i].pc;
            #1;
            chk($sformatf("v%0d_o_ready", i), 32'(bus.o_ready), 32'd1);
            tick();
            chk($sformatf("v%0d_o_valid", i), 32'(bus.o_valid), 32'd1);
            chk($sformatf("v%0d_opcode", i), 32'(bus.o_opcode), 32'(vecs[i].opcode));
            chk($sformatf("v%0d_rs", i), 32'(bus.o_rs), 32'(vecs[i].rs));
            chk($sformatf("v%0d_rt", i), 32'(bus.o_rt), 32'(vecs[i].rt));
            chk($sformatf("v%0d_rd", i), 32'(bus.o_rd), 32'(vecs[i].rd));
            chk($sformatf("v%0d_funct", i), 32'(bus.o_funct), 32'(vecs[i].funct));
            chk($sformatf("v%0d_extended", i), bus.o_extended, vecs[i].ext);
            chk($sformatf("v%0d_index", i), 32'(bus.o_instruction_index), 32'(vecs[i].index));
            chk($sformatf("v%0d_pc_next", i), bus.o_pc_next, vecs[i].pc);
        end
        chk("v2_sa_last_is_r", 32'(bus.o_hazard_stall), 32'd0);

        // Load-use hazard: rs=9 against a load to 9 in EX.
        bus.i_instruction = 32'h012A4020;
        bus.i_pc_next     = 32'h00002000;
        bus.i_ex_mem_read = 1'b1;
        bus.i_ex_rt       = 5'd9;
        #1;
        chk("hazard_o_ready", 32'(bus.o_ready), 32'd0);
        tick();
        chk("hazard_bubble_valid", 32'(bus.o_valid), 32'd0);
        chk("hazard_bubble_stall", 32'(bus.o_hazard_stall), 32'd1);
        bus.i_ex_mem_read = 1'b0;
        #1;
        chk("hazard_clear_ready", 32'(bus.o_ready), 32'd1);
        tick();
        chk("hazard_emit_valid", 32'(bus.o_valid), 32'd1);
        chk("hazard_emit_stall", 32'(bus.o_hazard_stall), 32'd0);
        chk("hazard_emit_pc", bus.o_pc_next, 32'h00002000);
        bus.i_valid = 1'b0;
        tick();
        chk("hazard_emit_once", 32'(bus.o_valid), 32'd0);

        // Load to register 0 in EX never stalls.
        bus.i_valid       = 1'b1;
        bus.i_instruction = 32'h00000000;
        bus.i_ex_mem_read = 1'b1;
        bus.i_ex_rt       = 5'd0;
        #1;
        chk("hazard_rt0_ready", 32'(bus.o_ready), 32'd1);
        bus.i_ex_mem_read = 1'b0;
        tick();

        // Writeback bypass on the accepting cycle, then normal read, then reg 0.
        bus.i_instruction = 32'h00A50000;
        bus.i_wb_enable   = 1'b1;
        bus.i_wb_sel      = 5'd5;
        bus.i_wb_data     = 32'hCAFEF00D;
        tick();
        chk("bypass_data_rs", bus.o_data_rs, 32'hCAFEF00D);
        chk("bypass_data_rt", bus.o_data_rt, 32'hCAFEF00D);
        bus.i_wb_sel  = 5'd0;
        bus.i_wb_data = 32'h12345678;
        bus.i_instruction = 32'h00050000;
        tick();
        chk("stored_data_rt", bus.o_data_rt, 32'hCAFEF00D);
        chk("reg0_bypass_zero", bus.o_data_rs, 32'd0);
        bus.i_wb_enable = 1'b0;
        tick();
        chk("reg0_stored_zero", bus.o_data_rs, 32'd0);

        // Backpressure hold for 3 cycles, writeback continuing, then flush.
        bus.i_instruction = 32'h2008FFFF;
        bus.i_pc_next     = 32'h00003000;
        tick();
        bus.i_ready       = 1'b0;
        bus.i_instruction = 32'h3C081234;
        bus.i_pc_next     = 32'h00003004;
        bus.i_wb_enable   = 1'b1;
        bus.i_wb_sel      = 5'd7;
        bus.i_wb_data     = 32'h0BADBEEF;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_o_ready", c), 32'(bus.o_ready), 32'd0);
            tick();
            chk($sformatf("bp%0d_o_valid", c), 32'(bus.o_valid), 32'd1);
            chk($sformatf("bp%0d_extended", c), bus.o_extended, 32'hFFFFFFFF);
            chk($sformatf("bp%0d_pc_next", c), bus.o_pc_next, 32'h00003000);
        end
        bus.i_wb_enable = 1'b0;
        bus.i_flush     = 1'b1;
        bus.i_ready     = 1'b1;
        #1;
        chk("flush_o_ready", 32'(bus.o_ready), 32'd0);
        tick();
        chk("flush_o_valid", 32'(bus.o_valid), 32'd0);
        chk("flush_stall", 32'(bus.o_hazard_stall), 32'd0);
        bus.i_flush       = 1'b0;
        bus.i_instruction = 32'h00070000;
        tick();
        chk("wb_during_backpressure", bus.o_data_rt, 32'h0BADBEEF);
        chk("after_flush_pc", bus.o_pc_next, 32'h00003004);

        // Asynchronous reset between edges, mid-stream.
        bus.i_instruction = 32'h00A50000;
        tick();
        chk("pre_reset_data_rs", bus.o_data_rs, 32'hCAFEF00D);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_o_valid", 32'(bus.o_valid), 32'd0);
        chk("async_data_rs", bus.o_data_rs, 32'd0);
        chk("async_data_rt", bus.o_data_rt, 32'd0);
        chk("async_extended", bus.o_extended, 32'd0);
        chk("async_pc_next", bus.o_pc_next, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_reset_valid", 32'(bus.o_valid), 32'd1);
        chk("post_reset_regfile_rs", bus.o_data_rs, 32'd0);
        chk("post_reset_regfile_rt", bus.o_data_rt, 32'd0);

        idle_inputs();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_pipe_stage.md
DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- NB_DATA, 32, datapath width, minimum 32.
- NB_REGISTER, 5, register-select width.
- N_REGS, 2**NB_REGISTER, register-file depth.
- ZERO_REG_HARDWIRED, 1, register 0 reads 0 and ignores writes.

REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- i_clock, in, 1, single clock; all state changes on rising edge.
- i_reset_n, in, 1, asynchronous active-low reset.
- i_valid, in, 1, upstream instruction valid.
- o_ready, out, 1, stage accepts the upstream instruction this cycle.
- i_instruction, in, NB_DATA, fetched instruction.
- i_pc_next, in, NB_DATA, fetched PC+4.
- i_ready, in, 1, downstream (EX) accepts.
- i_flush, in, 1, branch/jump squash.
- i_ex_mem_read, in, 1, instruction in EX is a load.
- i_ex_rt, in, NB_REGISTER, load destination in EX.
- i_wb_enable, in, 1, writeback enable.
- i_wb_sel, in, NB_REGISTER, writeback register.
- i_wb_data, in, NB_DATA, writeback data.
- o_valid, out, 1, decoded outputs valid.
- o_opcode, out, 6, instr[31:26].
- o_funct, out, 6, instr[5:0].
- o_rs / o_rt / o_rd / o_sa, out, NB_REGISTER each, instr fields.
- o_data_rs / o_data_rt, out, NB_DATA each, register operands.
- o_extended, out, NB_DATA, immediate extended per REQ-009.
- o_instruction_index, out, 26, instr[25:0].
- o_pc_next, out, NB_DATA, registered PC+4.
- o_hazard_stall, out, 1, load-use bubble inserted this cycle.

Function
REQ-003 All outputs except o_ready SHALL be registered; the stage SHALL have 1-cycle latency from acceptance to o_valid.
REQ-004 Accept = i_valid && o_ready; o_ready SHALL equal (!o_valid || i_ready) && !hazard && !i_flush.
REQ-005 Hazard SHALL be asserted when i_valid && i_ex_mem_read && i_ex_rt != 0 && (i_ex_rt == instr[25:21] || i_ex_rt == instr[20:16]).
REQ-006 On hazard with (!o_valid || i_ready), the stage SHALL register a bubble: o_valid=0, o_hazard_stall=1 for exactly that cycle; the instruction SHALL be held upstream, not dropped.
REQ-007 When o_valid && !i_ready, all output registers SHALL hold their values unchanged.
REQ-008 i_flush SHALL have highest priority: next cycle o_valid=0 and o_hazard_stall=0, and the incoming instruction SHALL be discarded.
REQ-009 Extension SHALL depend on opcode:
- 0x0C/0x0D/0x0E (ANDI/ORI/XORI): zero-extend.
- 0x0F (LUI): {imm16, 16'b0} zero-extended to NB_DATA.
- All other opcodes: sign-extend.
REQ-010 Register file writes SHALL occur on the rising edge when i_wb_enable and (i_wb_sel != 0 or !ZERO_REG_HARDWIRED).
REQ-011 Reads SHALL be combinational with write bypass: a same-cycle write to the selected register returns i_wb_data.
REQ-012 With ZERO_REG_HARDWIRED=1, register 0 SHALL read 0 regardless of bypass.
REQ-013 Writeback SHALL proceed during stall, hazard, flush and backpressure cycles.
REQ-014 When accept and writeback occur in the same cycle to the same register, the captured operand SHALL be the new value.

Reset
REQ-015 While i_reset_n=0, o_valid, o_hazard_stall and all data outputs SHALL be 0, and all N_REGS registers SHALL be 0.
REQ-016 Reset SHALL take effect asynchronously, mid-operation included; release SHALL be synchronised externally.
REQ-017 The first accept SHALL be possible on the first rising edge after release; o_ready=1 then.

Structure
REQ-018 Package decode_pkg SHALL hold opcode constants (ANDI, ORI, XORI, LUI), field bit positions and the extension-mode enum (SIGN, ZERO, UPPER).
REQ-019 The register file with bypass SHALL be sub-module register_file_bypass, parameterised by NB_DATA, NB_REGISTER, N_REGS, ZERO_REG_HARDWIRED.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Accept 0x2008FFFF (ADDI) with i_ready=1 -> next cycle o_valid=1, o_rt=8, o_extended=0xFFFFFFFF.
- ORI 0x3508FFFF -> o_extended=0x0000FFFF; LUI 0x3C081234 -> o_extended=0x12340000.
- i_ex_mem_read=1, i_ex_rt=9, instr rs=9 -> o_ready=0, one cycle of o_valid=0 with o_hazard_stall=1; after i_ex_mem_read drops, the instruction is emitted once.
- i_wb_enable=1, sel=5, data=0xCAFEF00D, same cycle as accepting rs=5 -> o_data_rs=0xCAFEF00D; write to reg 0 -> reads 0.
- o_valid=1, i_ready=0 for 3 cycles -> outputs stable, o_ready=0; then i_flush=1 -> o_valid=0 next cycle.
- i_reset_n pulled low between edges mid-stream -> all outputs 0 immediately, register file reads 0.
